// File: rtl/truth_table_sweeper_if.sv
// Sweeper <-> lab-board/q1 bundle: start request, q1 stimulus/response, sweep results.
// master = control side (drives start and returns f), slave = sweeper.
interface truth_table_sweeper_if #(
  parameter int N_IN = 4
);
  logic                   start;
  logic                   f_in;
  logic [N_IN-1:0]        abcd;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [N_IN:0]          err_count;
  logic [N_IN-1:0]        first_fail;
  logic [(1<<N_IN)-1:0]   fail_mask;

  modport master (
    output start, f_in,
    input  abcd, busy, done, pass, err_count, first_fail, fail_mask
  );

  modport slave (
    input  start, f_in,
    output abcd, busy, done, pass, err_count, first_fail, fail_mask
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table checker for q1: 2^N_IN vectors, SETTLE+2 cycles each, done one cycle after the last check; start ignored while busy.
// Optional TRUTH_TABLE_SWEEPER_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module truth_table_sweeper #(
  parameter int                   N_IN     = 4,
  parameter int                   SETTLE   = 2,
  parameter logic [(1<<N_IN)-1:0] EXPECTED = 16'hB0BB
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_sweeper_if.slave  bus
);
  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  typedef enum logic [2:0] {IDLE, APPLY, WAIT, CHECK, DONE} state_t;

  state_t          state;
  logic [N_IN-1:0] idx;
  logic [CW-1:0]   cnt;
  logic            mism;
  logic            last_vec;
  logic            finish;

  assign mism     = (bus.f_in != EXPECTED[idx]);
  assign last_vec = &idx;
`ifdef TRUTH_TABLE_SWEEPER_STOP_ON_FAIL_EN
  assign finish   = last_vec || mism;
`else
  assign finish   = last_vec;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      cnt            <= '0;
      bus.abcd       <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.pass       <= 1'b0;
      bus.err_count  <= '0;
      bus.first_fail <= '0;
      bus.fail_mask  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.err_count  <= '0;
            bus.first_fail <= '0;
            bus.fail_mask  <= '0;
            bus.pass       <= 1'b0;
            bus.busy       <= 1'b1;
            idx            <= '0;
            state          <= APPLY;
          end
        end
        APPLY: begin
          bus.abcd <= idx;
          cnt      <= CW'(SETTLE);
          state    <= (SETTLE == 0) ? CHECK : WAIT;
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= CHECK;
        end
        CHECK: begin
          if (mism) begin
            bus.fail_mask[idx] <= 1'b1;
            bus.err_count      <= bus.err_count + (N_IN+1)'(1);
            if (bus.err_count == '0) bus.first_fail <= idx;
          end
          // pass/done are registered here so they are valid in the same cycle as done
          if (finish) begin
            bus.done <= 1'b1;
            bus.pass <= (bus.err_count == '0) && !mism;
            state    <= DONE;
          end else begin
            idx   <= idx + N_IN'(1);
            state <= APPLY;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboarded bench for truth_table_sweeper: directed sweeps against a behavioural q1 with selectable faults.
// Expected results are queued at start; a negedge monitor compares them when done pulses.
module tb_truth_table_sweeper;
  typedef struct {
    int          lat;
    logic        pas;
    logic [4:0]  err;
    logic [3:0]  ff;
    logic [15:0] mask;
    logic [3:0]  abcd;
    int          t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] q1_tt = 16'hB0BB;
  int          mode = 0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  exp_t        last_e;
  bit          have_last = 0;

  truth_table_sweeper_if #(.N_IN(4)) bus();

  truth_table_sweeper #(.N_IN(4), .SETTLE(2), .EXPECTED(16'hB0BB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // q1 model: 0 = correct, 1 = f stuck at 0, 2 = f forced to 1 at index 10
  always_comb begin
    bus.f_in = 1'b0;
    case (mode)
      0:       bus.f_in = q1_tt[bus.abcd];
      1:       bus.f_in = 1'b0;
      default: bus.f_in = (bus.abcd == 4'hA) ? 1'b1 : q1_tt[bus.abcd];
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input int lat, input logic pas, input logic [4:0] err,
                              input logic [3:0] ff, input logic [15:0] mask, input logic [3:0] abcd);
    exp_t e;
    e.lat = lat; e.pas = pas; e.err = err; e.ff = ff; e.mask = mask; e.abcd = abcd; e.t = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: done pulsed with no sweep pending (cycle %0d), expected none", cyc + 1);
      end else begin
        mon_e = sb.pop_front();
        chk("done_cycle", cyc + 1, mon_e.t + mon_e.lat);
        chk("pass", bus.pass, mon_e.pas);
        chk("err_count", bus.err_count, mon_e.err);
        chk("first_fail", bus.first_fail, mon_e.ff);
        chk("fail_mask", bus.fail_mask, mon_e.mask);
        chk("abcd_final", bus.abcd, mon_e.abcd);
        chk("busy_in_done", bus.busy, 1'b1);
        last_e    = mon_e;
        have_last = 1;
      end
    end
  end

  task automatic start_sweep(input exp_t e, input bit push, output int t);
    @(negedge clk);
    bus.start = 1'b1;
    t   = cyc + 1;
    e.t = t;
    if (push) sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1'b1);
  endtask

  task automatic pulse_at(input int c);
    while (cyc < c) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < target) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: done count %0d, expected %0d", done_cnt, target);
    end else begin
      repeat (3) @(negedge clk);
      chk("hold_busy", bus.busy, 1'b0);
      if (have_last) begin
        chk("hold_err_count", bus.err_count, last_e.err);
        chk("hold_fail_mask", bus.fail_mask, last_e.mask);
        chk("hold_pass", bus.pass, last_e.pas);
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_abcd"}, bus.abcd, 4'h0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_done"}, bus.done, 1'b0);
    chk({tag, "_pass"}, bus.pass, 1'b0);
    chk({tag, "_err_count"}, bus.err_count, 5'd0);
    chk({tag, "_first_fail"}, bus.first_fail, 4'h0);
    chk({tag, "_fail_mask"}, bus.fail_mask, 16'h0000);
  endtask

  initial begin
    exp_t e_ok, e_s0, e_i10;
    int   t;
    bus.start = 1'b0;
    e_ok = mk(65, 1'b1, 5'd0, 4'h0, 16'h0000, 4'hF);
`ifdef TRUTH_TABLE_SWEEPER_STOP_ON_FAIL_EN
    e_s0  = mk(5, 1'b0, 5'd1, 4'h0, 16'h0001, 4'h0);
    e_i10 = mk(45, 1'b0, 5'd1, 4'hA, 16'h0400, 4'hA);
`else
    e_s0  = mk(65, 1'b0, 5'd9, 4'h0, 16'hB0BB, 4'hF);
    e_i10 = mk(65, 1'b0, 5'd1, 4'hA, 16'h0400, 4'hF);
`endif

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // correct q1: vector k is applied at edge T+1+4k
    mode = 0;
    start_sweep(e_ok, 1'b1, t);
    for (int k = 0; k < 16; k++) begin
      while (cyc < t + 3 + 4 * k) @(negedge clk);
      chk("abcd_step", bus.abcd, k);
    end
    wait_done(1);

    mode = 1;
    start_sweep(e_s0, 1'b1, t);
    wait_done(2);

    mode = 2;
    start_sweep(e_i10, 1'b1, t);
    wait_done(3);

    // extra starts while busy and during the DONE cycle are ignored
    mode = 0;
    start_sweep(e_ok, 1'b1, t);
    pulse_at(t + 10);
    pulse_at(t + 40);
    pulse_at(t + 64);
    wait_done(4);
    repeat (80) @(negedge clk);
    chk("no_extra_done", done_cnt, 4);

    // reset while waiting on vector 7
    mode = 2;
    start_sweep(e_i10, 1'b0, t);
    while (cyc < t + 29) @(negedge clk);
    chk("abcd_before_rst", bus.abcd, 4'h7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("midrst");
    repeat (80) @(negedge clk);
    chk("no_done_after_rst", done_cnt, 4);

    mode = 0;
    start_sweep(e_ok, 1'b1, t);
    wait_done(5);

    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
